aes_spi_master: RTL and testbench

- Host-side SPI master that feeds the AES decryption unit over its single-clock serial link and collects the decrypted block.
- On a start pulse it serialises key then ciphertext onto Mosi with cs_enc active, waits a fixed settle interval, then shifts the 128-bit result back in from Miso.
- Sits directly upstream of decryption_unit; both share clk, so one bit moves per clk cycle and there is no separate serial clock.

---
 rtl/aes_pkg.sv | 24 ++
 rtl/spi_shift_reg.sv | 33 +++
 rtl/aes_spi_master.sv | 128 ++++++++++++
 tb/tb_aes_spi_master.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// aes_pkg: shared widths, FSM state encoding and defaults for the AES host-side SPI master.
package aes_pkg;

  localparam int SETTLE_DEFAULT = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TX     = 3'd1,
    SETTLE = 3'd2,
    RX     = 3'd3,
    DONE   = 3'd4
  } state_e;

  function automatic int KW(input int nk);
    return 32 * nk;
  endfunction

  function automatic int BW(input int nb);
    return 32 * nb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_shift_reg.sv
`default_nettype none
// spi_shift_reg: width-N shift register with parallel load, MSB shift-out and LSB shift-in.
module spi_shift_reg #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [N-1:0] load_data_i,
  input  logic         shift_i,
  input  logic         sin_i,
  output logic         msb_o,
  output logic [N-1:0] next_o
);

  logic [N-1:0] data_q;

  // next_o is the post-shift value, letting the owner capture the final bit in the same edge
  assign next_o = {data_q[N-2:0], sin_i};
  assign msb_o  = data_q[N-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= load_data_i;
    end else if (shift_i) begin
      data_q <= next_o;
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_spi_master.sv
`default_nettype none
// aes_spi_master: serialises key then ciphertext onto Mosi, waits a settle gap,
// then shifts the decrypted block back in from Miso (one bit per clk).
module aes_spi_master #(
  parameter int  nk     = 8,
  parameter int  nb     = 4,
  parameter int  SETTLE = aes_pkg::SETTLE_DEFAULT,
  localparam int KW     = aes_pkg::KW(nk),
  localparam int BW     = aes_pkg::BW(nb)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] key_in,
  input  logic [BW-1:0] block_in,
  input  logic          Miso,
  output logic          Mosi,
  output logic          cs_enc,
  output logic          busy,
  output logic          done,
  output logic [BW-1:0] result
);

  localparam int TXN = KW + BW;
  localparam int CW  = $clog2(TXN + 1);

  aes_pkg::state_e state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   result_q, result_d;

  logic            tx_load, tx_msb, rx_shift;
  logic [BW-1:0]   rx_next;
  logic [TXN-1:0]  unused_tx_next;
  logic            unused_rx_msb;

  assign tx_load  = (state_q == aes_pkg::IDLE) && start;
  assign rx_shift = (state_q == aes_pkg::RX);

  spi_shift_reg #(.N(TXN)) u_tx_sr (
    .clk         (clk),
    .rst         (rst),
    .load_i      (tx_load),
    .load_data_i ({key_in, block_in}),
    .shift_i     (state_q == aes_pkg::TX),
    .sin_i       (1'b0),
    .msb_o       (tx_msb),
    .next_o      (unused_tx_next)
  );

  spi_shift_reg #(.N(BW)) u_rx_sr (
    .clk         (clk),
    .rst         (rst),
    .load_i      (tx_load),
    .load_data_i ({BW{1'b0}}),
    .shift_i     (rx_shift),
    .sin_i       (Miso),
    .msb_o       (unused_rx_msb),
    .next_o      (rx_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= aes_pkg::IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    result_d = result_q;
    Mosi     = 1'b0;
    cs_enc   = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      aes_pkg::IDLE: begin
        cnt_d = '0;
        if (start) state_d = aes_pkg::TX;
      end
      aes_pkg::TX: begin
        cs_enc = 1'b0;
        busy   = 1'b1;
        Mosi   = tx_msb;
        if (cnt_q == CW'(TXN - 1)) begin
          state_d = aes_pkg::SETTLE;
          cnt_d   = '0;
        end
      end
      aes_pkg::SETTLE: begin
        cs_enc = 1'b0;
        busy   = 1'b1;
        if (cnt_q == CW'(SETTLE - 1)) begin
          state_d = aes_pkg::RX;
          cnt_d   = '0;
        end
      end
      aes_pkg::RX: begin
        cs_enc = 1'b0;
        busy   = 1'b1;
        // Final Miso bit is folded in here so result is complete on entry to DONE
        if (cnt_q == CW'(BW - 1)) begin
          result_d = rx_next;
          state_d  = aes_pkg::DONE;
          cnt_d    = '0;
        end
      end
      aes_pkg::DONE: begin
        done    = 1'b1;
        cnt_d   = '0;
        state_d = aes_pkg::IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = aes_pkg::IDLE;
      end
    endcase
  end

  assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_spi_master.sv
`default_nettype none
// tb_aes_spi_master: randomized self-checking bench for the default (nk=8, SETTLE=2)
// and reduced (nk=4, SETTLE=1) builds, with a stub Miso slave and cycle-accurate model.
module tb_aes_spi_master;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         Miso = 1'b0;
  logic         sel = 1'b0;
  logic [255:0] key_r = '0;
  logic [127:0] blk_r = '0;

  logic         mosi_a, cs_a, busy_a, done_a;
  logic [127:0] res_a;
  logic         mosi_b, cs_b, busy_b, done_b;
  logic [127:0] res_b;

  int           checks = 0;
  int           failures = 0;
  logic [127:0] last_res = '0;

  always #5 clk = ~clk;

  aes_spi_master #(.nk(8), .nb(4), .SETTLE(2)) dut_a (
    .clk      (clk),
    .rst      (rst),
    .start    (start & ~sel),
    .key_in   (key_r),
    .block_in (blk_r),
    .Miso     (Miso),
    .Mosi     (mosi_a),
    .cs_enc   (cs_a),
    .busy     (busy_a),
    .done     (done_a),
    .result   (res_a)
  );

  aes_spi_master #(.nk(4), .nb(4), .SETTLE(1)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .start    (start & sel),
    .key_in   (key_r[127:0]),
    .block_in (blk_r),
    .Miso     (Miso),
    .Mosi     (mosi_b),
    .cs_enc   (cs_b),
    .busy     (busy_b),
    .done     (done_b),
    .result   (res_b)
  );

  wire         m_mosi = sel ? mosi_b : mosi_a;
  wire         m_cs   = sel ? cs_b   : cs_a;
  wire         m_busy = sel ? busy_b : busy_a;
  wire         m_done = sel ? done_b : done_a;
  wire [127:0] m_res  = sel ? res_b  : res_a;

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One complete transfer on the selected build; g0/g1 are cycles carrying a stray start.
  task automatic run_xfer(input string name, input logic [255:0] key, input logic [127:0] blk,
                          input logic [127:0] pat, input int g0, input int g1);
    int kw, st, txn, rx0, total, dcyc;
    int cs_low, first_low, cs_bad, busy_bad, mosi_bad, done_cnt, done_at, hold_bad;
    logic [383:0] got, exp;
    kw = sel ? 128 : 256;
    st = sel ? 1 : 2;
    txn = kw + 128;
    rx0 = txn + st + 1;
    total = txn + st + 128;
    dcyc = total + 1;
    cs_low = 0; first_low = -1; cs_bad = 0; busy_bad = 0; mosi_bad = 0;
    done_cnt = 0; done_at = -1; hold_bad = 0;
    got = '0;
    exp = sel ? {128'b0, key[127:0], blk} : {key, blk};
    key_r = key;
    blk_r = blk;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    key_r = {rand128(), rand128()};
    blk_r = rand128();
    for (int c = 1; c <= dcyc + 1; c++) begin
      Miso  = (c >= rx0 && c <= total) ? pat[127 - (c - rx0)] : 1'($urandom());
      start = (c == g0 || c == g1);
      if (m_cs === 1'b0) begin
        cs_low++;
        if (first_low < 0) first_low = c;
      end
      if (m_cs !== ((c <= total) ? 1'b0 : 1'b1)) cs_bad++;
      if (m_busy !== ((c <= total) ? 1'b1 : 1'b0)) busy_bad++;
      if (c <= txn) got[txn - c] = m_mosi;
      else if (m_mosi !== 1'b0) mosi_bad++;
      if (m_done === 1'b1) begin
        done_cnt++;
        done_at = c;
      end else if (m_done !== 1'b0) begin
        done_cnt += 100;
      end
      if (c < dcyc && m_res !== last_res) hold_bad++;
      if (c <= dcyc) begin
        @(posedge clk);
        #1;
      end
    end
    start = 1'b0;

    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s mosi_stream got=%h exp=%h", name, got, exp);
    end
    checks++;
    if (cs_low != total) begin
      failures++;
      $display("FAIL %s cs_low_window got=%0d exp=%0d", name, cs_low, total);
    end
    checks++;
    if (first_low != 1) begin
      failures++;
      $display("FAIL %s cs_first_low_cycle got=%0d exp=1", name, first_low);
    end
    checks++;
    if (cs_bad != 0) begin
      failures++;
      $display("FAIL %s cs_enc_shape bad_cycles=%0d exp=0", name, cs_bad);
    end
    checks++;
    if (busy_bad != 0) begin
      failures++;
      $display("FAIL %s busy_shape bad_cycles=%0d exp=0", name, busy_bad);
    end
    checks++;
    if (mosi_bad != 0) begin
      failures++;
      $display("FAIL %s mosi_idle_zero bad_cycles=%0d exp=0", name, mosi_bad);
    end
    checks++;
    if (done_cnt != 1 || done_at != dcyc) begin
      failures++;
      $display("FAIL %s done_pulse count=%0d at=%0d exp count=1 at=%0d", name, done_cnt, done_at, dcyc);
    end
    checks++;
    if (hold_bad != 0) begin
      failures++;
      $display("FAIL %s result_hold bad_cycles=%0d exp=0", name, hold_bad);
    end
    checks++;
    if (m_res !== pat) begin
      failures++;
      $display("FAIL %s result got=%h exp=%h", name, m_res, pat);
    end
    last_res = pat;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mosi_a, cs_a, busy_a, done_a, res_a} !== {1'b0, 1'b1, 1'b0, 1'b0, 128'b0}) begin
      failures++;
      $display("FAIL reset_a got=%b%b%b%b %h exp=0100 0", mosi_a, cs_a, busy_a, done_a, res_a);
    end
    checks++;
    if ({mosi_b, cs_b, busy_b, done_b, res_b} !== {1'b0, 1'b1, 1'b0, 1'b0, 128'b0}) begin
      failures++;
      $display("FAIL reset_b got=%b%b%b%b %h exp=0100 0", mosi_b, cs_b, busy_b, done_b, res_b);
    end
    @(negedge clk);
    rst = 1'b0;
    last_res = '0;
  endtask

  task automatic test_fips();
    logic [255:0] k;
    logic [127:0] b, p;
    k = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    b = 128'h8ea2b7ca516745bfeafc49904b496089;
    p = 128'h00112233445566778899aabbccddeeff;
    sel = 1'b0;
    run_xfer("fips", k, b, p, -1, -1);
  endtask

  task automatic test_busy_start();
    sel = 1'b0;
    run_xfer("busy_start", {rand128(), rand128()}, rand128(), rand128(), 50, 514);
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    run_xfer("b2b_first", {rand128(), rand128()}, rand128(), rand128(), -1, 515);
    run_xfer("b2b_second", {rand128(), rand128()}, rand128(), rand128(), -1, -1);
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    key_r = {rand128(), rand128()};
    blk_r = rand128();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (99) begin
      Miso = 1'($urandom());
      @(posedge clk);
    end
    #1;
    checks++;
    if (cs_a !== 1'b0 || busy_a !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_active cs=%b busy=%b exp cs=0 busy=1", cs_a, busy_a);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (cs_a !== 1'b1 || mosi_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_cs_mosi cs=%b mosi=%b exp cs=1 mosi=0", cs_a, mosi_a);
    end
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_busy_done busy=%b done=%b exp 0 0", busy_a, done_a);
    end
    checks++;
    if (res_a !== 128'b0) begin
      failures++;
      $display("FAIL reset_mid_result got=%h exp=0", res_a);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_res = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cs_a !== 1'b1 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_idle_after cs=%b busy=%b exp cs=1 busy=0", cs_a, busy_a);
    end
    run_xfer("after_reset", {rand128(), rand128()}, rand128(), rand128(), -1, -1);
  endtask

  task automatic test_random();
    sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_xfer("random_nk8", {rand128(), rand128()}, rand128(), rand128(),
               int'($urandom_range(2, 500)), -1);
    end
  endtask

  task automatic test_small_cfg();
    @(negedge clk);
    sel = 1'b1;
    last_res = '0;
    run_xfer("nk4_settle1_a", {rand128(), rand128()}, rand128(), rand128(), -1, -1);
    run_xfer("nk4_settle1_b", {rand128(), rand128()}, rand128(), rand128(), 200, 385);
  endtask

  initial begin
    test_reset();
    test_fips();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_small_cfg();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
`default_nettype wire
